// File: rtl/trap_sequencer.sv
// Trap entry/return sequencer: owns STATUS/SCAUSE/INTMASK/EPC, picks the winning cause,
// runs the pipeline flush handshake and redirects fetch to the vector or back to EPC.
module trap_sequencer #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] VEC_BASE = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [7:0]      irq_src,
  input  logic            csr_we,
  input  logic [1:0]      csr_addr,
  input  logic [7:0]      csr_wdata,
  output logic [7:0]      csr_rdata,
  output logic            flush_req,
  input  logic            flush_ack,
  input  logic [PC_W-1:0] epc_in,
  input  logic            sret,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            in_trap,
  output logic [7:0]      status_o
);

  typedef enum logic [2:0] {StIdle, StFlush, StEnter, StHandler, StReturn} state_e;

  state_e          state_q, state_d;
  logic [7:0]      status_q, status_d;
  logic [7:0]      scause_q, scause_d;
  logic [7:0]      intmask_q, intmask_d;
  logic [2:0]      cause_q, cause_d;
  logic [PC_W-1:0] epc_q, epc_d;

  logic [7:0] pend;
  logic       take;
  logic [2:0] win_idx;

  assign pend = scause_q & intmask_q;
  assign take = (|pend) & status_q[1] & ~status_q[0];

  // Scan from the top so the lowest set bit is the last (winning) assignment.
  always_comb begin
    win_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend[i]) win_idx = 3'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    scause_d  = scause_q;
    intmask_d = intmask_q;
    cause_d   = cause_q;
    epc_d     = epc_q;

    if (csr_we) begin
      unique case (csr_addr)
        2'd0:    status_d  = csr_wdata;
        2'd1:    scause_d  = scause_q & ~csr_wdata;
        2'd2:    intmask_d = csr_wdata;
        default: ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (take) begin
          state_d = StFlush;
          cause_d = win_idx;
        end
      end
      StFlush: begin
        if (flush_ack) begin
          state_d = StEnter;
          epc_d   = epc_in;
        end
      end
      StEnter: begin
        state_d           = StHandler;
        status_d[0]       = 1'b1;
        scause_d[cause_q] = 1'b0;
      end
      StHandler: begin
        if (sret) state_d = StReturn;
      end
      StReturn: begin
        state_d     = StIdle;
        status_d[0] = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    // Sources are applied last so a hardware set beats any same-cycle clear.
    scause_d = scause_d | irq_src;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      status_q  <= 8'h00;
      scause_q  <= 8'h00;
      intmask_q <= 8'h00;
      cause_q   <= 3'd0;
      epc_q     <= '0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      scause_q  <= scause_d;
      intmask_q <= intmask_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
    end
  end

  always_comb begin
    flush_req   = (state_q == StFlush);
    in_trap     = (state_q == StHandler);
    redirect    = 1'b0;
    redirect_pc = '0;
    if (state_q == StEnter) begin
      redirect    = 1'b1;
      redirect_pc = VEC_BASE + PC_W'({cause_q, 2'b00});
    end else if (state_q == StReturn) begin
      redirect    = 1'b1;
      redirect_pc = epc_q;
    end
  end

  always_comb begin
    unique case (csr_addr)
      2'd0:    csr_rdata = status_q;
      2'd1:    csr_rdata = scause_q;
      2'd2:    csr_rdata = intmask_q;
      default: csr_rdata = {5'b0, cause_q};
    endcase
  end

  assign status_o = status_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed literal checks plus randomized traffic compared every
// cycle against a behavioural trap model.
module tb_trap_sequencer;

  localparam int unsigned PC_W = 32;
  localparam logic [31:0] VBASE = 32'h0000_0100;

  localparam int PIdle = 0, PFlush = 1, PEnter = 2, PHandler = 3, PReturn = 4;

  logic            clk, rstn;
  logic [7:0]      irq_src, csr_wdata, csr_rdata, status_o;
  logic            csr_we, flush_req, flush_ack, sret, redirect, in_trap;
  logic [1:0]      csr_addr;
  logic [PC_W-1:0] epc_in, redirect_pc;

  int checks = 0;
  int failures = 0;

  trap_sequencer #(.PC_W(PC_W), .VEC_BASE(VBASE)) dut (
    .clk(clk), .rstn(rstn), .irq_src(irq_src), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .flush_req(flush_req),
    .flush_ack(flush_ack), .epc_in(epc_in), .sret(sret), .redirect(redirect),
    .redirect_pc(redirect_pc), .in_trap(in_trap), .status_o(status_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_phase, n_phase;
  logic [7:0]  m_status, m_scause, m_intmask, n_status, n_scause, n_intmask;
  int          m_cause, n_cause;
  logic [31:0] m_epc, n_epc;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  always_comb begin
    n_phase   = m_phase;
    n_status  = m_status;
    n_scause  = m_scause;
    n_intmask = m_intmask;
    n_cause   = m_cause;
    n_epc     = m_epc;
    if (csr_we && csr_addr == 2'd0) n_status = csr_wdata;
    if (csr_we && csr_addr == 2'd1) n_scause = m_scause & ~csr_wdata;
    if (csr_we && csr_addr == 2'd2) n_intmask = csr_wdata;
    if (m_phase == PIdle) begin
      if ((m_scause & m_intmask) != 0 && m_status[1] && !m_status[0]) begin
        n_phase = PFlush;
        n_cause = lowest(m_scause & m_intmask);
      end
    end else if (m_phase == PFlush) begin
      if (flush_ack) begin
        n_phase = PEnter;
        n_epc   = epc_in;
      end
    end else if (m_phase == PEnter) begin
      n_phase     = PHandler;
      n_status[0] = 1'b1;
      n_scause    = n_scause & ~(8'h01 << m_cause);
    end else if (m_phase == PHandler) begin
      if (sret) n_phase = PReturn;
    end else begin
      n_phase     = PIdle;
      n_status[0] = 1'b0;
    end
    n_scause = n_scause | irq_src;
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase <= PIdle; m_status <= 8'h00; m_scause <= 8'h00; m_intmask <= 8'h00;
      m_cause <= 0;     m_epc <= 32'h0;
    end else begin
      m_phase <= n_phase; m_status <= n_status; m_scause <= n_scause;
      m_intmask <= n_intmask; m_cause <= n_cause; m_epc <= n_epc;
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_pc;
    logic [7:0]  exp_rd;
    exp_pc = (m_phase == PEnter) ? VBASE + 32'(m_cause) * 4 :
             (m_phase == PReturn) ? m_epc : 32'h0;
    case (csr_addr)
      2'd0:    exp_rd = m_status;
      2'd1:    exp_rd = m_scause;
      2'd2:    exp_rd = m_intmask;
      default: exp_rd = 8'(m_cause);
    endcase
    chk("cmp_flush_req", 32'(flush_req), 32'(m_phase == PFlush));
    chk("cmp_redirect", 32'(redirect), 32'(m_phase == PEnter || m_phase == PReturn));
    chk("cmp_redirect_pc", redirect_pc, exp_pc);
    chk("cmp_in_trap", 32'(in_trap), 32'(m_phase == PHandler));
    chk("cmp_status", 32'(status_o), 32'(m_status));
    chk("cmp_rdata", 32'(csr_rdata), 32'(exp_rd));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    csr_addr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [7:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic wait_flush(input string nm);
    for (int i = 0; i < 10 && !flush_req; i++) tick();
    chk(nm, 32'(flush_req), 32'd1);
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    irq_src = v;
    tick();
    irq_src = 8'h00;
  endtask

  initial begin
    logic [7:0] d;
    rstn = 1'b0; irq_src = 8'h00; csr_we = 1'b0; csr_addr = 2'd0; csr_wdata = 8'h00;
    flush_ack = 1'b0; epc_in = 32'h0; sret = 1'b0;
    #1;
    chk("rst_flush_req", 32'(flush_req), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      chk("rst_rdata", 32'(d), 32'h0);
    end
    tick(); tick();
    rstn = 1'b1;
    tick();

    // Reset in the middle of FLUSH
    csr_write(2'd0, 8'h02);
    csr_write(2'd2, 8'h01);
    pulse_irq(8'h01);
    wait_flush("t1_flush_up");
    rstn = 1'b0;
    #1;
    chk("t1_flush_req", 32'(flush_req), 32'd0);
    chk("t1_status", 32'(status_o), 32'd0);
    chk("t1_redirect", 32'(redirect), 32'd0);
    chk("t1_in_trap", 32'(in_trap), 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // Timer entry
    csr_write(2'd0, 8'h02);
    csr_write(2'd2, 8'h01);
    pulse_irq(8'h01);
    wait_flush("t2_flush");
    flush_ack = 1'b1; epc_in = 32'h40;
    tick();
    flush_ack = 1'b0;
    chk("t2_redirect", 32'(redirect), 32'd1);
    chk("t2_vec", redirect_pc, 32'h100);
    tick();
    chk("t2_status", 32'(status_o), 32'h03);
    chk("t2_in_trap", 32'(in_trap), 32'd1);
    rd(2'd1, d);
    chk("t2_scause0", 32'(d[0]), 32'd0);

    // Return
    sret = 1'b1;
    tick();
    sret = 1'b0;
    chk("t5_redirect", 32'(redirect), 32'd1);
    chk("t5_epc", redirect_pc, 32'h40);
    tick();
    chk("t5_status", 32'(status_o), 32'h02);
    chk("t5_in_trap", 32'(in_trap), 32'd0);

    // Priority and EXL race on a STATUS write during ENTER
    csr_we = 1'b1; csr_addr = 2'd2; csr_wdata = 8'hFF; irq_src = 8'h06;
    tick();
    csr_we = 1'b0; irq_src = 8'h00;
    wait_flush("t3_flush1");
    rd(2'd3, d);
    chk("t3_cause", 32'(d), 32'd1);
    flush_ack = 1'b1; epc_in = 32'h80;
    tick();
    flush_ack = 1'b0;
    chk("t3_vec1", redirect_pc, 32'h104);
    tick();
    rd(2'd1, d);
    chk("t3_scause", 32'(d), 32'h04);
    sret = 1'b1;
    tick();
    sret = 1'b0;
    tick();
    wait_flush("t3_flush2");
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    chk("t3_vec2", redirect_pc, 32'h108);
    csr_write(2'd0, 8'h02);
    chk("t6_exl_wins", 32'(status_o), 32'h03);
    rd(2'd1, d);
    chk("t3_scause_clr", 32'(d), 32'h00);
    sret = 1'b1;
    tick();
    sret = 1'b0;
    tick();

    // Masking
    csr_write(2'd2, 8'h01);
    pulse_irq(8'h04);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_mask", 32'(flush_req), 32'd0);
    end
    csr_write(2'd0, 8'h03);
    csr_write(2'd2, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_exl", 32'(flush_req), 32'd0);
    end
    csr_write(2'd0, 8'h00);
    csr_write(2'd1, 8'hFF);

    // W1C racing a hardware set
    csr_we = 1'b1; csr_addr = 2'd1; csr_wdata = 8'h01; irq_src = 8'h01;
    tick();
    csr_we = 1'b0; irq_src = 8'h00;
    rd(2'd1, d);
    chk("t6_set_wins", 32'(d), 32'h01);
    csr_write(2'd1, 8'hFF);
    rd(2'd1, d);
    chk("t6_cleared", 32'(d), 32'h00);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      csr_we   = ($urandom_range(0, 7) == 0);
      csr_addr = 2'($urandom_range(0, 3));
      if (csr_addr == 2'd0) begin
        case ($urandom_range(0, 4))
          0, 1:    csr_wdata = 8'h02;
          2:       csr_wdata = 8'h00;
          3:       csr_wdata = 8'h03;
          default: csr_wdata = 8'($urandom);
        endcase
      end else begin
        csr_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 9) == 0)      irq_src = 8'h01 << $urandom_range(0, 7);
      else if ($urandom_range(0, 39) == 0) irq_src = 8'($urandom);
      else                                 irq_src = 8'h00;
      flush_ack = ($urandom_range(0, 2) == 0);
      sret      = ($urandom_range(0, 5) == 0);
      epc_in    = $urandom;
      rstn      = ($urandom_range(0, 499) != 0);
      tick();
    end
    rstn = 1'b1; csr_we = 1'b0; irq_src = 8'h00; flush_ack = 1'b0; sret = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
